// File: rtl/cv32e40p_apu_core_pkg.sv
// Shared types for the APU dispatcher: latency classes and the queue entry layout.
package cv32e40p_apu_core_pkg;

   localparam int APU_WADDR_W = 6;

   typedef enum logic [1:0] {
      LAT_SINGLE = 2'd0,
      LAT_TWO    = 2'd1,
      LAT_MULTI  = 2'd2,
      LAT_LONG   = 2'd3
   } apu_lat_e;

   typedef struct packed {
      logic [APU_WADDR_W-1:0] waddr;
      apu_lat_e               lat;
      logic                   valid;
   } apu_entry_t;

endpackage

// File: rtl/cv32e40p_apu_hazard_cmp.sv
// Matches a list of register addresses against the destinations of the valid
// in-flight queue entries. Address 0 never matches.
module cv32e40p_apu_hazard_cmp #(
   parameter int N      = 3,
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 4
) (
   input  logic [N-1:0][ADDR_W-1:0]     regs,
   input  logic [N-1:0]                 regs_valid,
   input  logic [DEPTH-1:0][ADDR_W-1:0] entry_waddr,
   input  logic [DEPTH-1:0]             entry_valid,
   output logic                         match
);

   // Any valid source/destination equal to any live entry destination
   always_comb begin
      match = 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
         for (int s = 0; s < N; s++) begin
            if (entry_valid[e] && regs_valid[s] && (regs[s] != '0) &&
                (regs[s] == entry_waddr[e]))
               match = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cv32e40p_apu_disp_q.sv
// In-order APU dispatcher with a DEPTH-entry request queue. Granted requests
// record their destination and latency class; results return in order and
// are paired with the oldest entry.
//
// Handshake: apu_req_o is a valid; apu_gnt_i is its ready. A transfer (push)
// happens in any cycle where both are high. While req is high without grant
// the presented instruction must be held stable. apu_rvalid_i is an
// unconditional in-order response; it always pops the head when one exists.
module cv32e40p_apu_disp_q
   import cv32e40p_apu_core_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 6,
   parameter int NREAD  = 3,
   parameter int NWRITE = 2,
   parameter int LAT_W  = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable_i,
   input  logic [ADDR_W-1:0]             apu_waddr_i,
   input  logic [LAT_W-1:0]              apu_lat_i,
   input  logic                          is_decoding_i,
   input  logic [NREAD-1:0][ADDR_W-1:0]  read_regs_i,
   input  logic [NREAD-1:0]              read_regs_valid_i,
   input  logic [NWRITE-1:0][ADDR_W-1:0] write_regs_i,
   input  logic [NWRITE-1:0]             write_regs_valid_i,
   output logic                          apu_req_o,
   input  logic                          apu_gnt_i,
   input  logic                          apu_rvalid_i,
   output logic [ADDR_W-1:0]             apu_waddr_o,
   output logic                          apu_singlecycle_o,
   output logic                          apu_multicycle_o,
   output logic                          read_dep_o,
   output logic                          write_dep_o,
   output logic                          stall_o,
   output logic                          active_o,
   output logic [$clog2(DEPTH):0]        count_o,
   output logic                          perf_type_o,
   output logic                          perf_cont_o,
   output logic                          err_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   apu_entry_t              q [DEPTH];
   logic [PTR_W-1:0]        rd_ptr;
   logic [PTR_W-1:0]        wr_ptr;
   logic [CNT_W-1:0]        count;
   logic                    err;

   logic                    full;
   logic                    empty;
   logic                    push;
   logic                    pop;
   apu_entry_t              head;
   logic [DEPTH-1:0][ADDR_W-1:0] live_waddr;
   logic [DEPTH-1:0]        live_valid;
   logic                    rd_match;
   logic                    wr_match;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   // A same-cycle pop frees a slot, so rvalid can unblock a full queue.
   assign apu_req_o = enable_i & (~full | apu_rvalid_i);
   assign push      = apu_req_o & apu_gnt_i;
   assign pop       = apu_rvalid_i & ~empty;

   assign stall_o     = enable_i & ~push;
   assign perf_type_o = enable_i & full & ~apu_rvalid_i;
   assign perf_cont_o = apu_req_o & ~apu_gnt_i;

   assign head              = q[rd_ptr];
   assign apu_waddr_o       = empty ? '0 : ADDR_W'(head.waddr);
   assign apu_singlecycle_o = ~empty & (head.lat == LAT_SINGLE);
   assign apu_multicycle_o  = ~empty & ((head.lat == LAT_MULTI) | (head.lat == LAT_LONG));

   assign active_o = ~empty;
   assign count_o  = count;
   assign err_o    = err;

   // Live entries for hazards; the head popping now is forwarded by ID instead
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         live_waddr[i] = ADDR_W'(q[i].waddr);
         live_valid[i] = q[i].valid & ~(pop & (rd_ptr == PTR_W'(i)));
      end
   end

   cv32e40p_apu_hazard_cmp #(.N(NREAD), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_read_cmp (
      .regs        (read_regs_i),
      .regs_valid  (read_regs_valid_i),
      .entry_waddr (live_waddr),
      .entry_valid (live_valid),
      .match       (rd_match)
   );

   cv32e40p_apu_hazard_cmp #(.N(NWRITE), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_write_cmp (
      .regs        (write_regs_i),
      .regs_valid  (write_regs_valid_i),
      .entry_waddr (live_waddr),
      .entry_valid (live_valid),
      .match       (wr_match)
   );

   assign read_dep_o  = is_decoding_i & rd_match;
   assign write_dep_o = is_decoding_i & wr_match;

   // Queue storage, pointers, occupancy and the sticky error flag
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) q[i] <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         err    <= 1'b0;
      end else begin
         // Pop clears first so a push into the same slot (full queue) wins.
         if (pop) begin
            q[rd_ptr].valid <= 1'b0;
            rd_ptr          <= rd_ptr + 1'b1;
         end
         if (push) begin
            q[wr_ptr].waddr <= APU_WADDR_W'(apu_waddr_i);
            q[wr_ptr].lat   <= apu_lat_e'(apu_lat_i);
            q[wr_ptr].valid <= 1'b1;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (apu_rvalid_i && empty) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cv32e40p_apu_disp_q.sv
// Bench for the APU dispatcher: hand vectors, corner sequences and random
// traffic against a queue-based reference model.
module tb_cv32e40p_apu_disp_q;

   logic            clk = 1'b0;
   logic            rst;
   logic            enable_i;
   logic [5:0]      apu_waddr_i;
   logic [1:0]      apu_lat_i;
   logic            is_decoding_i;
   logic [2:0][5:0] read_regs_i;
   logic [2:0]      read_regs_valid_i;
   logic [1:0][5:0] write_regs_i;
   logic [1:0]      write_regs_valid_i;
   logic            apu_req_o;
   logic            apu_gnt_i;
   logic            apu_rvalid_i;
   logic [5:0]      apu_waddr_o;
   logic            apu_singlecycle_o;
   logic            apu_multicycle_o;
   logic            read_dep_o;
   logic            write_dep_o;
   logic            stall_o;
   logic            active_o;
   logic [2:0]      count_o;
   logic            perf_type_o;
   logic            perf_cont_o;
   logic            err_o;

   int tests = 0;
   int fails = 0;

   // model: each element is {waddr[5:0], lat[1:0]}, oldest at index 0
   logic [7:0] exp_q[$];
   logic       exp_err;

   cv32e40p_apu_disp_q dut (
      .clk(clk), .rst(rst), .enable_i(enable_i), .apu_waddr_i(apu_waddr_i),
      .apu_lat_i(apu_lat_i), .is_decoding_i(is_decoding_i),
      .read_regs_i(read_regs_i), .read_regs_valid_i(read_regs_valid_i),
      .write_regs_i(write_regs_i), .write_regs_valid_i(write_regs_valid_i),
      .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i), .apu_rvalid_i(apu_rvalid_i),
      .apu_waddr_o(apu_waddr_o), .apu_singlecycle_o(apu_singlecycle_o),
      .apu_multicycle_o(apu_multicycle_o), .read_dep_o(read_dep_o),
      .write_dep_o(write_dep_o), .stall_o(stall_o), .active_o(active_o),
      .count_o(count_o), .perf_type_o(perf_type_o), .perf_cont_o(perf_cont_o),
      .err_o(err_o)
   );

   // clock
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      enable_i = 0; apu_waddr_i = 0; apu_lat_i = 0; apu_gnt_i = 0; apu_rvalid_i = 0;
      is_decoding_i = 0; read_regs_i = '0; read_regs_valid_i = '0;
      write_regs_i = '0; write_regs_valid_i = '0;
   endtask

   // model predictions for the current inputs
   function automatic logic m_full(); return exp_q.size() == 4; endfunction
   function automatic logic m_req(); return enable_i && (!m_full() || apu_rvalid_i); endfunction

   function automatic logic m_dep(input logic wr);
      logic hit = 0;
      for (int j = 0; j < exp_q.size(); j++) begin
         if (j == 0 && apu_rvalid_i) continue;   // head is being written back now
         if (!wr) begin
            for (int s = 0; s < 3; s++)
               if (read_regs_valid_i[s] && read_regs_i[s] != 0 && read_regs_i[s] == exp_q[j][7:2]) hit = 1;
         end else begin
            for (int s = 0; s < 2; s++)
               if (write_regs_valid_i[s] && write_regs_i[s] != 0 && write_regs_i[s] == exp_q[j][7:2]) hit = 1;
         end
      end
      return is_decoding_i && hit;
   endfunction

   // compare combinational outputs with the model (called mid-cycle)
   task automatic check_comb();
      logic nonempty = exp_q.size() != 0;
      logic req = m_req();
      chk("req", apu_req_o, req);
      chk("stall", stall_o, enable_i && !(req && apu_gnt_i));
      chk("perf_type", perf_type_o, enable_i && m_full() && !apu_rvalid_i);
      chk("perf_cont", perf_cont_o, req && !apu_gnt_i);
      chk("waddr_o", apu_waddr_o, nonempty ? exp_q[0][7:2] : 6'd0);
      chk("single", apu_singlecycle_o, nonempty && exp_q[0][1:0] == 2'd0);
      chk("multi", apu_multicycle_o, nonempty && exp_q[0][1:0] >= 2'd2);
      chk("read_dep", read_dep_o, m_dep(0));
      chk("write_dep", write_dep_o, m_dep(1));
   endtask

   // clock edge, model update, registered-output check
   task automatic advance();
      logic push = m_req() && apu_gnt_i;
      logic pop  = apu_rvalid_i && exp_q.size() != 0;
      logic erv  = apu_rvalid_i && exp_q.size() == 0;
      logic [7:0] ent = {apu_waddr_i, apu_lat_i};
      @(posedge clk);
      if (pop) void'(exp_q.pop_front());
      if (push) exp_q.push_back(ent);
      if (erv) exp_err = 1;
      @(negedge clk);
      chk("count", count_o, exp_q.size());
      chk("active", active_o, exp_q.size() != 0);
      chk("err", err_o, exp_err);
   endtask

   task automatic cycle();
      #1;
      check_comb();
      advance();
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      @(posedge clk);
      exp_q.delete();
      exp_err = 0;
      @(negedge clk);
      rst = 0;
      #1;
      chk("rst_count", count_o, 0);
      chk("rst_active", active_o, 0);
      chk("rst_waddr_o", apu_waddr_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_req", apu_req_o, 0);
   endtask

   typedef struct {
      logic       en;
      logic [5:0] wa;
      logic [1:0] lat;
      logic       gnt;
      logic       rv;
      logic [5:0] x_waddr;
      logic       x_req;
      logic       x_stall;
      logic       x_ptype;
      logic [2:0] x_cnt;
   } vec_t;

   vec_t vecs[12];
   int   cont_cycles;

   initial begin
      idle_inputs();
      rst = 1;
      exp_err = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      do_reset();

      // single push/pop, then fill to full, push+pop at full, drain
      vecs[0]  = '{1, 5, 2, 1, 0, 0, 1, 0, 0, 1};
      vecs[1]  = '{0, 0, 0, 0, 1, 5, 0, 0, 0, 0};
      vecs[2]  = '{1, 1, 0, 1, 0, 0, 1, 0, 0, 1};
      vecs[3]  = '{1, 2, 0, 1, 0, 1, 1, 0, 0, 2};
      vecs[4]  = '{1, 3, 1, 1, 0, 1, 1, 0, 0, 3};
      vecs[5]  = '{1, 4, 3, 1, 0, 1, 1, 0, 0, 4};
      vecs[6]  = '{1, 5, 2, 1, 0, 1, 0, 1, 1, 4};
      vecs[7]  = '{1, 5, 2, 1, 1, 1, 1, 0, 0, 4};
      vecs[8]  = '{0, 0, 0, 0, 1, 2, 0, 0, 0, 3};
      vecs[9]  = '{0, 0, 0, 0, 1, 3, 0, 0, 0, 2};
      vecs[10] = '{0, 0, 0, 0, 1, 4, 0, 0, 0, 1};
      vecs[11] = '{0, 0, 0, 0, 1, 5, 0, 0, 0, 0};
      for (int i = 0; i < 12; i++) begin
         idle_inputs();
         enable_i = vecs[i].en; apu_waddr_i = vecs[i].wa; apu_lat_i = vecs[i].lat;
         apu_gnt_i = vecs[i].gnt; apu_rvalid_i = vecs[i].rv;
         #1;
         chk($sformatf("vec%0d_waddr_o", i), apu_waddr_o, vecs[i].x_waddr);
         chk($sformatf("vec%0d_req", i), apu_req_o, vecs[i].x_req);
         chk($sformatf("vec%0d_stall", i), stall_o, vecs[i].x_stall);
         chk($sformatf("vec%0d_perf_type", i), perf_type_o, vecs[i].x_ptype);
         if (i == 1) chk("vec1_multi", apu_multicycle_o, 1);
         check_comb();
         advance();
         chk($sformatf("vec%0d_count", i), count_o, vecs[i].x_cnt);
      end

      // grant withheld for three cycles
      idle_inputs();
      enable_i = 1; apu_waddr_i = 6'd12; apu_lat_i = 2'd1;
      cont_cycles = 0;
      for (int i = 0; i < 4; i++) begin
         apu_gnt_i = (i == 3);
         #1;
         if (perf_cont_o && stall_o) cont_cycles++;
         check_comb();
         advance();
      end
      chk("cont_cycles", cont_cycles, 3);
      chk("cont_count", count_o, 1);
      idle_inputs(); apu_rvalid_i = 1; cycle();

      // hazards against an in-flight waddr 7
      idle_inputs(); enable_i = 1; apu_waddr_i = 7; apu_lat_i = 1; apu_gnt_i = 1; cycle();
      idle_inputs();
      is_decoding_i = 1;
      read_regs_i[0] = 7; read_regs_i[1] = 0; read_regs_i[2] = 9; read_regs_valid_i = 3'b111;
      write_regs_i[0] = 7; write_regs_valid_i = 2'b01;
      #1;
      chk("haz_read", read_dep_o, 1);
      chk("haz_write", write_dep_o, 1);
      is_decoding_i = 0;
      #1;
      chk("haz_nodec_read", read_dep_o, 0);
      chk("haz_nodec_write", write_dep_o, 0);
      is_decoding_i = 1; apu_rvalid_i = 1;
      #1;
      chk("haz_pop_read", read_dep_o, 0);
      chk("haz_pop_write", write_dep_o, 0);
      cycle();

      // rvalid on empty queue is sticky until reset
      idle_inputs(); apu_rvalid_i = 1; cycle();
      chk("err_set", err_o, 1);
      idle_inputs(); cycle();
      chk("err_hold", err_o, 1);
      chk("err_count", count_o, 0);
      do_reset();

      // reset with two entries in flight
      idle_inputs(); enable_i = 1; apu_gnt_i = 1; apu_waddr_i = 3; cycle();
      apu_waddr_i = 4; cycle();
      do_reset();
      idle_inputs(); enable_i = 1; apu_gnt_i = 1; apu_waddr_i = 9; apu_lat_i = 0; cycle();
      idle_inputs(); apu_rvalid_i = 1;
      #1;
      chk("post_rst_head", apu_waddr_o, 9);
      chk("post_rst_single", apu_singlecycle_o, 1);
      cycle();

      // random traffic against the model
      for (int i = 0; i < 400; i++) begin
         enable_i = ($urandom_range(0, 3) != 0);
         apu_waddr_i = 6'($urandom_range(0, 7));
         apu_lat_i = 2'($urandom_range(0, 3));
         apu_gnt_i = ($urandom_range(0, 3) != 0);
         apu_rvalid_i = (exp_q.size() != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
         is_decoding_i = $urandom_range(0, 1);
         for (int s = 0; s < 3; s++) read_regs_i[s] = 6'($urandom_range(0, 7));
         for (int s = 0; s < 2; s++) write_regs_i[s] = 6'($urandom_range(0, 7));
         read_regs_valid_i = 3'($urandom_range(0, 7));
         write_regs_valid_i = 2'($urandom_range(0, 3));
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cv32e40p_apu_disp_q.md
Name: cv32e40p_apu_disp_q

Overview:
- In-order APU dispatcher with a request queue. Supports up to DEPTH outstanding APU requests; the existing dispatcher supports a single one.
- Stores the destination register and latency class of each granted request. Pairs each rvalid with the oldest entry.
- Raises read/write hazard flags for ID against every in-flight destination.
- Sits in the EX stage between ID/APU operands and the shared APU interconnect. Drives the writeback-port selection for APU results.

Parameters:
- DEPTH, 4, maximum outstanding granted requests (power of 2, at least 2).
- ADDR_W, 6, register address width (GPR plus FPR space).
- NREAD, 3, read operands checked for hazards.
- NWRITE, 2, write targets checked for hazards.
- LAT_W, 2, latency-class width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- enable_i  in  1  ID presents a valid APU instruction.
- apu_waddr_i  in  ADDR_W  destination register of the presented instruction.
- apu_lat_i  in  LAT_W  latency class (0 = single cycle, 1 = two cycle, 2/3 = multicycle).
- is_decoding_i  in  1  qualifies the hazard outputs.
- read_regs_i  in  NREAD×ADDR_W  source registers of the instruction in ID.
- read_regs_valid_i  in  NREAD  per-source valid.
- write_regs_i  in  NWRITE×ADDR_W  destinations of the instruction in ID.
- write_regs_valid_i  in  NWRITE  per-destination valid.
- apu_req_o  out  1  request to the interconnect.
- apu_gnt_i  in  1  grant.
- apu_rvalid_i  in  1  result valid (in order).
- apu_waddr_o  out  ADDR_W  destination of the head entry.
- apu_singlecycle_o  out  1  head latency class is 0.
- apu_multicycle_o  out  1  head latency class is 2 or 3.
- read_dep_o  out  1  RAW hazard.
- write_dep_o  out  1  WAW hazard.
- stall_o  out  1  EX must hold the presented instruction.
- active_o  out  1  queue not empty.
- count_o  out  $clog2(DEPTH)+1  number of occupied entries.
- perf_type_o  out  1  stalled because the queue is full.
- perf_cont_o  out  1  stalled waiting for grant.
- err_o  out  1  sticky: rvalid received with an empty queue.

Behaviour:
- Reset:
  - Synchronous on rst high.
  - Queue empty; rd/wr pointers and count cleared; err_o cleared.
  - All outputs 0, including apu_waddr_o = 0.
- Queue: circular buffer of DEPTH entries {waddr, lat, valid}. Pointers are $clog2(DEPTH) bits and wrap naturally. full = (count == DEPTH).
- Request:
  - apu_req_o = enable_i & (~full | apu_rvalid_i). A pop in the same cycle frees a slot; this is a combinational rvalid→req path.
  - Push happens on apu_req_o & apu_gnt_i: entry at wr_ptr = {apu_waddr_i, apu_lat_i}, and wr_ptr advances.
  - Inputs must stay stable while apu_req_o is high without grant.
- Stall and performance flags:
  - stall_o = enable_i & ~(apu_req_o & apu_gnt_i).
  - perf_type_o = enable_i & full & ~apu_rvalid_i.
  - perf_cont_o = apu_req_o & ~apu_gnt_i.
- Response:
  - apu_rvalid_i with count > 0 pops the head; rd_ptr advances.
  - apu_waddr_o, apu_singlecycle_o and apu_multicycle_o reflect the head entry combinationally. They are valid in the rvalid cycle and forced to 0 when the queue is empty.
  - apu_rvalid_i with count == 0 sets err_o; no state change.
- Simultaneous push and pop:
  - count unchanged; both pointers advance.
  - Legal at full, and legal on a single-entry queue (the head pops and the new entry is written).
- Grant in the same cycle as the push: a granted instruction is visible in count_o, active_o and the hazard logic from the next cycle.
- Hazards:
  - read_dep_o = is_decoding_i & OR over (valid entry e, valid source s) of (read_regs_i[s] == e.waddr).
  - write_dep_o uses the same rule over write_regs_i.
  - The head entry popping this cycle is excluded from both; the result is being written now and is forwarded by ID.
  - Register address 0 matches nothing.
- active_o = (count != 0).
- Throughput: one push and one pop per cycle; zero-cycle dispatch latency when the grant is immediate.
- Reset mid-operation: all in-flight entries are discarded. Later rvalids are reported via err_o (the interconnect must be reset together with the core).

Decomposition:
- Add to cv32e40p_apu_core_pkg:
  - apu_lat_e enum: LAT_SINGLE = 0, LAT_TWO = 1, LAT_MULTI = 2, LAT_LONG = 3.
  - Entry struct typedef parametrised by ADDR_W via the localparam APU_WADDR_W = 6.
- Sub-module: cv32e40p_apu_hazard_cmp, the match of a register list against the valid-entry vector. Instantiated once for the read list and once for the write list.

Test Plan:
- Reset then enable_i = 1, waddr = 5, lat = 2, gnt = 1 → req = 1, stall = 0; next cycle count = 1, active = 1. rvalid → waddr_o = 5, multicycle = 1; count returns to 0.
- Four grants without rvalid (waddr 1, 2, 3, 4; DEPTH = 4), fifth enable_i → req = 0, stall = 1, perf_type = 1. Assert rvalid same cycle → req = 1, push and pop together, count stays 4; subsequent rvalids return waddr 2, 3, 4, 5 in order.
- enable_i = 1, gnt = 0 for 3 cycles then 1 → perf_cont = 1 and stall = 1 for exactly 3 cycles; exactly one entry pushed.
- Queue holds waddr 7; ID decoding with read_regs = {7, 0, 9} all valid → read_dep = 1. Same cycle with rvalid → read_dep = 0. is_decoding = 0 → read_dep = 0. write_regs = {7} → write_dep = 1.
- rvalid with empty queue → err_o = 1 and stays 1; count stays 0. Then rst = 1 for one cycle → err_o = 0.
- Two grants, then rst asserted → next cycle count = 0, active = 0, apu_waddr_o = 0; a new push lands at entry 0.
